// File: rtl/vga_pkg.sv
// Shared constants and types for the memory-mapped VGA bus controller.
package vga_pkg;

  localparam logic [2:0] REG_X      = 3'd0;
  localparam logic [2:0] REG_Y      = 3'd1;
  localparam logic [2:0] REG_PIXEL  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_COL_LO = 3'd5;
  localparam logic [2:0] REG_COL_HI = 3'd6;
  localparam logic [2:0] REG_FILL   = 3'd7;

  localparam int unsigned CTRL_AUTO_INC   = 0;
  localparam int unsigned CTRL_FILL_GO    = 1;
  localparam int unsigned CTRL_STEP       = 2;
  localparam int unsigned CTRL_FILL_ABORT = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  localparam logic [15:0] DEF_COLOUR_STEP = 16'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vga_xy_counter.sv
// Wrapping X/Y position counter with clear, per-axis load and raster increment.
module vga_xy_counter #(
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 7,
  parameter int unsigned X_MAX  = 160,
  parameter int unsigned Y_MAX  = 120
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_ld_x,
  input  logic              i_ld_y,
  input  logic              i_inc,
  input  logic [X_BITS-1:0] i_x,
  input  logic [Y_BITS-1:0] i_y,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic [X_BITS-1:0] o_x_nxt_c,
  output logic [Y_BITS-1:0] o_y_nxt_c
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX - 1);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [X_BITS-1:0] w_x_nxt;
  logic [Y_BITS-1:0] w_y_nxt;

  // Clear beats load beats increment; X runs fastest and carries into Y.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_clr) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (i_ld_x || i_ld_y) begin
      if (i_ld_x) w_x_nxt = i_x;
      if (i_ld_y) w_y_nxt = i_y;
    end else if (i_inc) begin
      if (r_x >= X_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y >= Y_LAST) ? '0 : r_y + Y_BITS'(1);
      end else begin
        w_x_nxt = r_x + X_BITS'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_x_nxt_c = w_x_nxt;
  assign o_y_nxt_c = w_y_nxt;

endmodule

// File: rtl/vga_bus_ctrl.sv
// Processor-bus register bank driving a frame-buffer port, fill engine and colour word.
module vga_bus_ctrl #(
  parameter logic [7:0]  BASE_ADDR   = 8'hB0,
  parameter int unsigned X_BITS      = 8,
  parameter int unsigned Y_BITS      = 7,
  parameter int unsigned X_MAX       = 160,
  parameter int unsigned Y_MAX       = 120,
  parameter int unsigned PIX_BITS    = 1,
  parameter logic [15:0] COLOUR_STEP = vga_pkg::DEF_COLOUR_STEP,
  parameter logic [15:0] COLOUR_INIT = 16'h0000
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  inout  wire  [7:0]               BUS_DATA,
  input  logic [7:0]               BUS_ADDR,
  input  logic                     BUS_WE,
  output logic [X_BITS+Y_BITS-1:0] FB_ADDR,
  output logic [PIX_BITS-1:0]      FB_WDATA,
  output logic                     FB_WE,
  input  logic [PIX_BITS-1:0]      FB_RDATA,
  output logic [15:0]              CONFIG_COLOURS,
  output logic                     BUSY
);

  import vga_pkg::*;

  localparam int unsigned A_BITS = X_BITS + Y_BITS;
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX - 1);

  fill_state_e           r_state;
  fill_state_e           w_state_nxt;
  logic                  r_auto_inc;
  logic                  r_step;
  logic                  r_done;
  logic                  r_busy;
  logic [PIX_BITS-1:0]   r_fill_data;
  logic [15:0]           r_colour;
  logic                  r_fb_we;
  logic [A_BITS-1:0]     r_fb_addr;
  logic [PIX_BITS-1:0]   r_fb_wdata;
  logic                  r_rd_en;
  logic [7:0]            r_rd_data;

  logic [7:0]            w_din;
  logic [7:0]            w_ofs;
  logic [2:0]            w_reg;
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_idle;
  logic                  w_go;
  logic                  w_abort;
  logic                  w_pix_wr;
  logic                  w_fill_clr;
  logic                  w_fill_inc;
  logic                  w_fill_wr;
  logic                  w_fill_last;
  logic                  w_done_set;
  logic [7:0]            w_rd_mux;

  logic [X_BITS-1:0]     w_cur_x, w_cur_x_nxt, w_fill_x, w_fill_x_nxt;
  logic [Y_BITS-1:0]     w_cur_y, w_cur_y_nxt, w_fill_y, w_fill_y_nxt;

  // Address decode: window of eight registers starting at BASE_ADDR.
  assign w_din    = BUS_DATA;
  assign w_ofs    = BUS_ADDR - BASE_ADDR;
  assign w_hit    = (w_ofs[7:3] == 5'd0);
  assign w_reg    = w_ofs[2:0];
  assign w_wr     = w_hit & BUS_WE;
  assign w_rd     = w_hit & ~BUS_WE;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_go     = w_wr & (w_reg == REG_CTRL) & w_din[CTRL_FILL_GO];
  assign w_abort  = w_wr & (w_reg == REG_CTRL) & w_din[CTRL_FILL_ABORT];
  assign w_pix_wr = w_idle & w_wr & (w_reg == REG_PIXEL);
  assign w_fill_last = (w_fill_x == X_LAST) && (w_fill_y == Y_LAST);

  vga_xy_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) u_cursor (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_clr     (1'b0),
    .i_ld_x    (w_idle & w_wr & (w_reg == REG_X)),
    .i_ld_y    (w_idle & w_wr & (w_reg == REG_Y)),
    .i_inc     (w_pix_wr & r_auto_inc),
    .i_x       (w_din[X_BITS-1:0]),
    .i_y       (w_din[Y_BITS-1:0]),
    .o_x       (w_cur_x),
    .o_y       (w_cur_y),
    .o_x_nxt_c (w_cur_x_nxt),
    .o_y_nxt_c (w_cur_y_nxt)
  );

  // Fill counter always holds the address currently presented on FB_ADDR.
  vga_xy_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) u_fill (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_clr     (w_fill_clr),
    .i_ld_x    (1'b0),
    .i_ld_y    (1'b0),
    .i_inc     (w_fill_inc),
    .i_x       ('0),
    .i_y       ('0),
    .o_x       (w_fill_x),
    .o_y       (w_fill_y),
    .o_x_nxt_c (w_fill_x_nxt),
    .o_y_nxt_c (w_fill_y_nxt)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_clr  = 1'b0;
    w_fill_inc  = 1'b0;
    w_fill_wr   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_FILL;
          w_fill_clr  = 1'b1;
          w_fill_wr   = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fill_last) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_fill_inc = 1'b1;
          w_fill_wr  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame-buffer port: idle address tracks the cursor with no lag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= '0;
    end else begin
      r_fb_we <= w_fill_wr | w_pix_wr;
      if (w_fill_wr) begin
        r_fb_addr  <= {w_fill_y_nxt, w_fill_x_nxt};
        r_fb_wdata <= r_fill_data;
      end else if (w_pix_wr) begin
        r_fb_addr  <= {w_cur_y, w_cur_x};
        r_fb_wdata <= w_din[PIX_BITS-1:0];
      end else begin
        r_fb_addr  <= {w_cur_y_nxt, w_cur_x_nxt};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_auto_inc  <= 1'b0;
      r_step      <= 1'b0;
      r_fill_data <= '0;
      r_colour    <= COLOUR_INIT;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_FILL);
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_auto_inc <= w_din[CTRL_AUTO_INC];
        r_step     <= w_din[CTRL_STEP];
      end
      if (w_idle && w_wr && (w_reg == REG_FILL)) r_fill_data <= w_din[PIX_BITS-1:0];
      if (w_wr && (w_reg == REG_COL_LO)) begin
        r_colour[7:0] <= w_din;
      end else if (w_wr && (w_reg == REG_COL_HI)) begin
        r_colour[15:8] <= w_din;
      end else if (w_wr && (w_reg == REG_CTRL) && w_din[CTRL_STEP] && !r_step) begin
        r_colour <= r_colour + COLOUR_STEP;
      end
      // A completion in the same cycle as a STATUS read stays visible.
      if (w_done_set)                         r_done <= 1'b1;
      else if (w_rd && (w_reg == REG_STATUS)) r_done <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_reg)
      REG_X:      w_rd_mux = 8'(w_cur_x);
      REG_Y:      w_rd_mux = 8'(w_cur_y);
      REG_PIXEL:  w_rd_mux = 8'(FB_RDATA);
      REG_CTRL:   w_rd_mux = {5'd0, r_step, 1'b0, r_auto_inc};
      REG_STATUS: w_rd_mux = {6'd0, r_done, r_busy};
      REG_COL_LO: w_rd_mux = r_colour[7:0];
      REG_COL_HI: w_rd_mux = r_colour[15:8];
      REG_FILL:   w_rd_mux = 8'(r_fill_data);
      default:    w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_en   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_en <= w_rd;
      if (w_rd) r_rd_data <= w_rd_mux;
    end
  end

  assign BUS_DATA       = r_rd_en ? r_rd_data : 8'bz;
  assign FB_ADDR        = r_fb_addr;
  assign FB_WDATA       = r_fb_wdata;
  assign FB_WE          = r_fb_we;
  assign CONFIG_COLOURS = r_colour;
  assign BUSY           = r_busy;

endmodule
